// File: rtl/xor_keystream_gen_pkg.sv
// Shared types and defaults for the serial-seeded Galois keystream generator.
package xor_keystream_gen_pkg;

    localparam int unsigned DefaultM    = 32;
    localparam logic [31:0] DefaultTaps = 32'h8020_0003;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StReady = 2'd2,
        StErr   = 2'd3
    } state_e;

endpackage

// File: rtl/galois_lfsr_step.sv
// One combinational Galois LFSR advance: shift right, fold the taps in when bit 0 exits set.
module galois_lfsr_step
    import xor_keystream_gen_pkg::*;
#(
    parameter int unsigned M    = DefaultM,
    parameter logic [M-1:0] TAPS = M'(DefaultTaps)
) (
    input  logic [M-1:0] lfsr,
    output logic [M-1:0] lfsr_next
);

    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

endmodule

// File: rtl/xor_keystream_gen.sv
// Keystream source: serial seed load with daisy-chain out, then Galois LFSR bits on a
// valid/ready handshake to the downstream XOR stage.
module xor_keystream_gen
    import xor_keystream_gen_pkg::*;
#(
    parameter int unsigned M    = DefaultM,
    parameter logic [M-1:0] TAPS = M'(DefaultTaps)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_en,
    input  logic       cfg_i,
    output logic       cfg_o,
    input  logic       ks_ready,
    output logic       ks_valid,
    output logic       ks_bit,
    output logic       err,
    output logic [1:0] state_o
);

    localparam int unsigned CntW = $clog2(M + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(M);

    state_e          state_q;
    logic [M-1:0]    lfsr_q;
    logic [M-1:0]    lfsr_step;
    logic [CntW-1:0] cnt_q;
    logic            cfg_o_q;

    galois_lfsr_step #(
        .M    (M),
        .TAPS (TAPS)
    ) u_step (
        .lfsr      (lfsr_q),
        .lfsr_next (lfsr_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            cfg_o_q <= 1'b0;
        end else if (cfg_en) begin
            // Loading pre-empts every state; the seed bit lands on this very edge.
            state_q <= StLoad;
            lfsr_q  <= {cfg_i, lfsr_q[M-1:1]};
            cfg_o_q <= lfsr_q[0];
            if (state_q != StLoad) begin
                cnt_q <= CntW'(1);
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            unique case (state_q)
                StLoad: begin
                    state_q <= (cnt_q == CntMax && lfsr_q != '0) ? StReady : StErr;
                end
                StReady: begin
                    if (ks_ready) begin
                        lfsr_q <= lfsr_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ks_valid = (state_q == StReady);
    assign ks_bit   = ks_valid & lfsr_q[0];
    assign err      = (state_q == StErr);
    assign state_o  = state_q;
    assign cfg_o    = cfg_o_q;

endmodule
